// File: rtl/huffman_mcu_scheduler_if.sv
// rtl/huffman_mcu_scheduler_if.sv - block source and encoder handshake bundle for the MCU scheduler
interface huffman_mcu_scheduler_if;
    logic         req_y;
    logic         req_cb;
    logic         req_cr;
    logic [639:0] blk_y;
    logic [639:0] blk_cb;
    logic [639:0] blk_cr;
    logic         ack_y;
    logic         ack_cb;
    logic         ack_cr;
    logic         huff_start;
    logic         huff_active;
    logic [639:0] zigzag_pix_out;
    logic [1:0]   comp_id;
    logic         table_sel;
    logic [9:0]   dc_pred;

    modport master (
        input  req_y, req_cb, req_cr, blk_y, blk_cb, blk_cr, huff_active,
        output ack_y, ack_cb, ack_cr, huff_start, zigzag_pix_out, comp_id, table_sel, dc_pred
    );

    modport slave (
        output req_y, req_cb, req_cr, blk_y, blk_cb, blk_cr, huff_active,
        input  ack_y, ack_cb, ack_cr, huff_start, zigzag_pix_out, comp_id, table_sel, dc_pred
    );
endinterface

// File: rtl/huffman_mcu_scheduler.sv
// rtl/huffman_mcu_scheduler.sv - shares one Huffman encoder among Y/Cb/Cr sources in JPEG MCU order
module huffman_mcu_scheduler #(
    parameter int Y_BLOCKS    = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    frame_start,
    input  logic [15:0]             mcu_count,
    huffman_mcu_scheduler_if.master link,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    timeout_err
);
    typedef enum logic [2:0] {IDLE, SELECT, START, WAIT_ACT, WAIT_DONE, DONE} state_t;

    localparam logic [2:0] YB   = 3'(Y_BLOCKS);
    localparam logic [2:0] LAST = 3'(Y_BLOCKS + 1);
    localparam int         TW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    state_t        state;
    logic [2:0]    seq_idx;
    logic [15:0]   mcu_cnt;
    logic [15:0]   mcu_total;
    logic [TW-1:0] tcnt;
    logic [9:0]    dc_y, dc_cb, dc_cr;

    logic          req_cur;
    logic [639:0]  blk_cur;
    logic [2:0]    seq_next;
    logic [1:0]    comp_next;
    logic [9:0]    coeff0;
    logic [9:0]    dc_next;

    function automatic logic [1:0] comp_of(input logic [2:0] s);
        if (s < YB)       return 2'd0;
        else if (s == YB) return 2'd1;
        else              return 2'd2;
    endfunction

    always_comb begin
        req_cur   = 1'b0;
        blk_cur   = link.blk_y;
        case (link.comp_id)
            2'd0:    begin req_cur = link.req_y;  blk_cur = link.blk_y;  end
            2'd1:    begin req_cur = link.req_cb; blk_cur = link.blk_cb; end
            default: begin req_cur = link.req_cr; blk_cur = link.blk_cr; end
        endcase
        seq_next  = (seq_idx == LAST) ? 3'd0 : seq_idx + 3'd1;
        comp_next = comp_of(seq_next);
        coeff0    = link.zigzag_pix_out[9:0];
        // The predictor shown next must already include the block just finished.
        case (comp_next)
            2'd0:    dc_next = (link.comp_id == 2'd0) ? coeff0 : dc_y;
            2'd1:    dc_next = (link.comp_id == 2'd1) ? coeff0 : dc_cb;
            default: dc_next = (link.comp_id == 2'd2) ? coeff0 : dc_cr;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            seq_idx             <= '0;
            mcu_cnt             <= '0;
            mcu_total           <= '0;
            tcnt                <= '0;
            dc_y                <= '0;
            dc_cb               <= '0;
            dc_cr               <= '0;
            link.ack_y          <= 1'b0;
            link.ack_cb         <= 1'b0;
            link.ack_cr         <= 1'b0;
            link.huff_start     <= 1'b0;
            link.zigzag_pix_out <= '0;
            link.comp_id        <= '0;
            link.table_sel      <= 1'b0;
            link.dc_pred        <= '0;
            busy                <= 1'b0;
            frame_done          <= 1'b0;
            timeout_err         <= 1'b0;
        end else begin
            link.ack_y      <= 1'b0;
            link.ack_cb     <= 1'b0;
            link.ack_cr     <= 1'b0;
            link.huff_start <= 1'b0;
            frame_done      <= 1'b0;
            case (state)
                IDLE: if (frame_start) begin
                    mcu_total      <= mcu_count;
                    mcu_cnt        <= '0;
                    seq_idx        <= '0;
                    link.comp_id   <= 2'd0;
                    link.table_sel <= 1'b0;
                    dc_y           <= '0;
                    dc_cb          <= '0;
                    dc_cr          <= '0;
                    link.dc_pred   <= '0;
                    timeout_err    <= 1'b0;
                    busy           <= 1'b1;
                    state          <= (mcu_count == 16'd0) ? DONE : SELECT;
                end
                SELECT: if (req_cur) begin
                    link.zigzag_pix_out <= blk_cur;
                    case (link.comp_id)
                        2'd0:    link.ack_y  <= 1'b1;
                        2'd1:    link.ack_cb <= 1'b1;
                        default: link.ack_cr <= 1'b1;
                    endcase
                    state <= START;
                end
                START: begin
                    link.huff_start <= 1'b1;
                    tcnt            <= '0;
                    state           <= WAIT_ACT;
                end
                WAIT_ACT: begin
                    if (!link.huff_active && tcnt >= TMAX) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                        if (link.huff_active) state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!link.huff_active) begin
                        case (link.comp_id)
                            2'd0:    dc_y  <= coeff0;
                            2'd1:    dc_cb <= coeff0;
                            default: dc_cr <= coeff0;
                        endcase
                        seq_idx        <= seq_next;
                        link.comp_id   <= comp_next;
                        link.table_sel <= (comp_next != 2'd0);
                        link.dc_pred   <= dc_next;
                        if (seq_idx == LAST) begin
                            mcu_cnt <= mcu_cnt + 16'd1;
                            state   <= (mcu_cnt + 16'd1 == mcu_total) ? DONE : SELECT;
                        end else begin
                            state <= SELECT;
                        end
                    end else if (tcnt >= TMAX) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_huffman_mcu_scheduler.sv
// tb/tb_huffman_mcu_scheduler.sv - scoreboard bench for huffman_mcu_scheduler (Y_BLOCKS=1 and Y_BLOCKS=4 instances)
module tb_huffman_mcu_scheduler;
    typedef struct packed {
        logic [1:0]   comp;
        logic         tsel;
        logic [9:0]   dc;
        logic [639:0] blk;
    } blk_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n = 1'b0;
    logic        fs_a = 1'b0, fs_b = 1'b0;
    logic [15:0] mc_a = '0, mc_b = '0;
    logic        busy_a, fd_a, te_a, busy_b, fd_b, te_b;

    huffman_mcu_scheduler_if ifa();
    huffman_mcu_scheduler_if ifb();

    huffman_mcu_scheduler #(.Y_BLOCKS(1), .TIMEOUT_CYC(64)) u_a (
        .clock(clock), .reset_n(reset_n), .frame_start(fs_a), .mcu_count(mc_a),
        .link(ifa.master), .busy(busy_a), .frame_done(fd_a), .timeout_err(te_a));

    huffman_mcu_scheduler #(.Y_BLOCKS(4), .TIMEOUT_CYC(16)) u_b (
        .clock(clock), .reset_n(reset_n), .frame_start(fs_b), .mcu_count(mc_b),
        .link(ifb.master), .busy(busy_b), .frame_done(fd_b), .timeout_err(te_b));

    int checks = 0, passed = 0;
    int len_a = 20, len_b = 4;
    bit en_a = 1'b1, en_b = 1'b1;
    int cnt_a = 0, cnt_b = 0;
    int hs_a = 0, hs_b = 0, fdn_a = 0, fdn_b = 0, ackn_a = 0, ackn_b = 0;
    int rd_a = 0, rd_b = 0;
    blk_t obs_a[$], obs_b[$], exp_a[$], exp_b[$];
    int ack_log_b[$];

    // Encoder models plus observation of pulses, all on the falling edge.
    always @(negedge clock) begin
        if (!reset_n) cnt_a = 0;
        else if (ifa.huff_start === 1'b1 && en_a) cnt_a = len_a;
        ifa.huff_active = (cnt_a != 0);
        if (cnt_a != 0) cnt_a--;
        if (!reset_n) cnt_b = 0;
        else if (ifb.huff_start === 1'b1 && en_b) cnt_b = len_b;
        ifb.huff_active = (cnt_b != 0);
        if (cnt_b != 0) cnt_b--;

        if (ifa.huff_start === 1'b1) begin
            obs_a.push_back({ifa.comp_id, ifa.table_sel, ifa.dc_pred, ifa.zigzag_pix_out});
            hs_a++;
        end
        if (ifb.huff_start === 1'b1) begin
            obs_b.push_back({ifb.comp_id, ifb.table_sel, ifb.dc_pred, ifb.zigzag_pix_out});
            hs_b++;
        end
        if (fd_a === 1'b1) fdn_a++;
        if (fd_b === 1'b1) fdn_b++;
        if ((ifa.ack_y | ifa.ack_cb | ifa.ack_cr) === 1'b1) ackn_a++;
        if (ifb.ack_y === 1'b1)  begin ack_log_b.push_back(0); ackn_b++; end
        if (ifb.ack_cb === 1'b1) begin ack_log_b.push_back(1); ackn_b++; end
        if (ifb.ack_cr === 1'b1) begin ack_log_b.push_back(2); ackn_b++; end
    end

    function automatic logic [639:0] mkblk(input logic [9:0] c0);
        logic [639:0] b;
        for (int k = 0; k < 20; k++) b[32*k +: 32] = $urandom;
        b[9:0] = c0;
        return b;
    endfunction

    function automatic blk_t mkexp(input logic [1:0] c, input logic [9:0] dc, input logic [639:0] b);
        blk_t e;
        e.comp = c;
        e.tsel = (c != 2'd0);
        e.dc   = dc;
        e.blk  = b;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clock); #2; end
    endtask

    task automatic pulse_a(input logic [15:0] m);
        mc_a = m; fs_a = 1'b1; tick(1); fs_a = 1'b0;
    endtask

    task automatic test_reset;
        ifa.req_y = 0; ifa.req_cb = 0; ifa.req_cr = 0; ifa.blk_y = '0; ifa.blk_cb = '0; ifa.blk_cr = '0;
        ifb.req_y = 0; ifb.req_cb = 0; ifb.req_cr = 0; ifb.blk_y = '0; ifb.blk_cb = '0; ifb.blk_cr = '0;
        reset_n = 1'b0;
        tick(3);
        checks++; if ({busy_a, fd_a, te_a} !== 3'b000) $display("FAIL reset_flags_a: got %b want 000", {busy_a, fd_a, te_a}); else passed++;
        checks++; if ({ifa.huff_start, ifa.ack_y, ifa.ack_cb, ifa.ack_cr} !== 4'b0) $display("FAIL reset_pulses_a: got %b want 0000", {ifa.huff_start, ifa.ack_y, ifa.ack_cb, ifa.ack_cr}); else passed++;
        checks++; if ({ifa.comp_id, ifa.table_sel, ifa.dc_pred} !== 13'b0) $display("FAIL reset_comp_a: got %h want 0", {ifa.comp_id, ifa.table_sel, ifa.dc_pred}); else passed++;
        checks++; if (ifa.zigzag_pix_out !== '0) $display("FAIL reset_zigzag_a: got %h want 0", ifa.zigzag_pix_out); else passed++;
        checks++; if ({busy_b, fd_b, te_b, ifb.huff_start, ifb.comp_id, ifb.dc_pred} !== 16'b0) $display("FAIL reset_b: got %h want 0", {busy_b, fd_b, te_b, ifb.huff_start, ifb.comp_id, ifb.dc_pred}); else passed++;
        reset_n = 1'b1;
        tick(2);
        checks++; if (busy_a !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy_a); else passed++;
    endtask

    task automatic test_mcu_order;
        int h0, f0, a0;
        blk_t o;
        ifa.blk_y = mkblk(10'd5); ifa.blk_cb = mkblk(-10'sd7); ifa.blk_cr = mkblk(10'd9);
        ifa.req_y = 1; ifa.req_cb = 1; ifa.req_cr = 1;
        exp_a.delete();
        for (int m = 0; m < 2; m++) begin
            exp_a.push_back(mkexp(2'd0, (m == 0) ? 10'd0 : 10'd5, ifa.blk_y));
            exp_a.push_back(mkexp(2'd1, (m == 0) ? 10'd0 : -10'sd7, ifa.blk_cb));
            exp_a.push_back(mkexp(2'd2, (m == 0) ? 10'd0 : 10'd9, ifa.blk_cr));
        end
        h0 = hs_a; f0 = fdn_a; a0 = ackn_a; rd_a = obs_a.size();
        pulse_a(16'd2);
        for (int i = 0; i < 600 && fd_a !== 1'b1; i++) tick(1);
        checks++; if (fd_a !== 1'b1) $display("FAIL order_frame_done: got %b want 1 within 600 cycles", fd_a); else passed++;
        tick(2);
        checks++; if (hs_a - h0 != 6) $display("FAIL order_start_count: got %0d want 6", hs_a - h0); else passed++;
        checks++; if (ackn_a - a0 != 6) $display("FAIL order_ack_count: got %0d want 6", ackn_a - a0); else passed++;
        checks++; if (fdn_a - f0 != 1) $display("FAIL order_done_count: got %0d want 1", fdn_a - f0); else passed++;
        for (int i = 0; i < exp_a.size(); i++) begin
            checks++;
            if (rd_a >= obs_a.size()) begin $display("FAIL order_missing: block %0d absent, got %0d want %0d", i, obs_a.size(), rd_a + 1); continue; end
            passed++;
            o = obs_a[rd_a]; rd_a++;
            checks++; if (o.comp !== exp_a[i].comp) $display("FAIL order_comp%0d: got %0d want %0d", i, o.comp, exp_a[i].comp); else passed++;
            checks++; if (o.tsel !== exp_a[i].tsel) $display("FAIL order_tsel%0d: got %0d want %0d", i, o.tsel, exp_a[i].tsel); else passed++;
            checks++; if (o.dc !== exp_a[i].dc) $display("FAIL order_dc%0d: got %0d want %0d", i, $signed(o.dc), $signed(exp_a[i].dc)); else passed++;
            checks++; if (o.blk !== exp_a[i].blk) $display("FAIL order_blk%0d: got %h want %h", i, o.blk[63:0], exp_a[i].blk[63:0]); else passed++;
        end
    endtask

    task automatic test_y4_order;
        logic [9:0]   c0[4];
        logic [639:0] yblk[4];
        int ord[6];
        int base, h0, yi;
        blk_t o;
        c0[0] = 10'd100; c0[1] = -10'sd3; c0[2] = 10'd50; c0[3] = 10'd7;
        ord[0] = 0; ord[1] = 0; ord[2] = 0; ord[3] = 0; ord[4] = 1; ord[5] = 2;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) yblk[k] = mkblk(c0[k]);
            ifb.blk_cb = mkblk(10'd20); ifb.blk_cr = mkblk(-10'sd40);
            yi = 0; ifb.blk_y = yblk[0];
            ifb.req_y = 1; ifb.req_cb = 1; ifb.req_cr = 1;
            exp_b.delete();
            for (int k = 0; k < 4; k++) exp_b.push_back(mkexp(2'd0, (k == 0) ? 10'd0 : c0[k-1], yblk[k]));
            exp_b.push_back(mkexp(2'd1, 10'd0, ifb.blk_cb));
            exp_b.push_back(mkexp(2'd2, 10'd0, ifb.blk_cr));
            base = ack_log_b.size(); rd_b = obs_b.size(); h0 = hs_b;
            mc_b = 16'd1; fs_b = 1'b1; tick(1); fs_b = 1'b0;
            for (int i = 0; i < 400 && fd_b !== 1'b1; i++) begin
                tick(1);
                if (ifb.ack_y === 1'b1 && yi < 3) begin yi++; ifb.blk_y = yblk[yi]; end
            end
            checks++; if (fd_b !== 1'b1) $display("FAIL y4_frame_done%0d: got %b want 1 within 400 cycles", f, fd_b); else passed++;
            tick(2);
            checks++; if (hs_b - h0 != 6) $display("FAIL y4_start_count%0d: got %0d want 6", f, hs_b - h0); else passed++;
            for (int j = 0; j < 6; j++) begin
                int got;
                got = (base + j < ack_log_b.size()) ? ack_log_b[base + j] : -1;
                checks++; if (got != ord[j]) $display("FAIL y4_ack_order%0d_%0d: got %0d want %0d", f, j, got, ord[j]); else passed++;
            end
            for (int i = 0; i < exp_b.size(); i++) begin
                checks++;
                if (rd_b >= obs_b.size()) begin $display("FAIL y4_missing%0d: block %0d absent, got %0d want %0d", f, i, obs_b.size(), rd_b + 1); continue; end
                passed++;
                o = obs_b[rd_b]; rd_b++;
                checks++; if (o.comp !== exp_b[i].comp) $display("FAIL y4_comp%0d_%0d: got %0d want %0d", f, i, o.comp, exp_b[i].comp); else passed++;
                checks++; if (o.tsel !== exp_b[i].tsel) $display("FAIL y4_tsel%0d_%0d: got %0d want %0d", f, i, o.tsel, exp_b[i].tsel); else passed++;
                checks++; if (o.dc !== exp_b[i].dc) $display("FAIL y4_dc%0d_%0d: got %0d want %0d", f, i, $signed(o.dc), $signed(exp_b[i].dc)); else passed++;
                checks++; if (o.blk !== exp_b[i].blk) $display("FAIL y4_blk%0d_%0d: got %h want %h", f, i, o.blk[63:0], exp_b[i].blk[63:0]); else passed++;
            end
        end
    endtask

    task automatic test_timeout;
        int f0;
        bit seen;
        blk_t o;
        blk_t e;
        en_b = 1'b0;
        ifb.blk_y = mkblk(10'd11);
        ifb.req_y = 1; ifb.req_cb = 1; ifb.req_cr = 1;
        e = mkexp(2'd0, 10'd0, ifb.blk_y);
        rd_b = obs_b.size(); f0 = fdn_b;
        mc_b = 16'd1; fs_b = 1'b1; tick(1); fs_b = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (ifb.huff_start === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) $display("FAIL timeout_start: got no huff_start want one within 20 cycles"); else passed++;
        tick(15);
        checks++; if ({te_b, busy_b} !== 2'b01) $display("FAIL timeout_early: got err/busy %b want 01 after 15 cycles", {te_b, busy_b}); else passed++;
        tick(1);
        checks++; if (te_b !== 1'b1) $display("FAIL timeout_err: got %b want 1 on 16th cycle", te_b); else passed++;
        checks++; if (busy_b !== 1'b0) $display("FAIL timeout_idle: got busy %b want 0", busy_b); else passed++;
        tick(3);
        checks++; if (fdn_b != f0) $display("FAIL timeout_no_done: got %0d frame_done want 0", fdn_b - f0); else passed++;
        checks++;
        if (rd_b >= obs_b.size()) $display("FAIL timeout_obs: got %0d starts want %0d", obs_b.size(), rd_b + 1);
        else begin
            passed++;
            o = obs_b[rd_b]; rd_b++;
            checks++; if (o !== e) $display("FAIL timeout_block: got comp %0d dc %0d want comp %0d dc %0d", o.comp, $signed(o.dc), e.comp, $signed(e.dc)); else passed++;
        end
        en_b = 1'b1;
    endtask

    task automatic test_zero_count;
        int h0, a0, f0;
        ifb.req_y = 1; ifb.req_cb = 1; ifb.req_cr = 1;
        h0 = hs_b; a0 = ackn_b; f0 = fdn_b;
        mc_b = 16'd0; fs_b = 1'b1; tick(1); fs_b = 1'b0;
        checks++; if (te_b !== 1'b0) $display("FAIL zero_err_cleared: got %b want 0", te_b); else passed++;
        checks++; if ({busy_b, fd_b} !== 2'b10) $display("FAIL zero_first_cycle: got busy/done %b want 10", {busy_b, fd_b}); else passed++;
        tick(1);
        checks++; if ({busy_b, fd_b} !== 2'b01) $display("FAIL zero_done: got busy/done %b want 01", {busy_b, fd_b}); else passed++;
        tick(2);
        checks++; if (hs_b != h0 || ackn_b != a0) $display("FAIL zero_no_activity: got %0d starts %0d acks want 0 0", hs_b - h0, ackn_b - a0); else passed++;
        checks++; if (fdn_b - f0 != 1) $display("FAIL zero_done_count: got %0d want 1", fdn_b - f0); else passed++;
    endtask

    task automatic test_busy_ignore;
        int h0, f0;
        blk_t o;
        ifa.req_y = 0; ifa.req_cb = 0; ifa.req_cr = 0;
        ifa.blk_y = mkblk(10'd33); ifa.blk_cb = mkblk(10'd44); ifa.blk_cr = mkblk(10'd55);
        exp_a.delete();
        exp_a.push_back(mkexp(2'd0, 10'd0, ifa.blk_y));
        exp_a.push_back(mkexp(2'd1, 10'd0, ifa.blk_cb));
        exp_a.push_back(mkexp(2'd2, 10'd0, ifa.blk_cr));
        h0 = hs_a; f0 = fdn_a; rd_a = obs_a.size();
        pulse_a(16'd1);
        tick(3);
        checks++; if (busy_a !== 1'b1 || hs_a != h0) $display("FAIL ignore_waiting: got busy %b starts %0d want 1 0", busy_a, hs_a - h0); else passed++;
        pulse_a(16'd3);
        tick(2);
        checks++; if (busy_a !== 1'b1) $display("FAIL ignore_still_busy: got %b want 1", busy_a); else passed++;
        ifa.req_y = 1; ifa.req_cb = 1; ifa.req_cr = 1;
        for (int i = 0; i < 400 && fd_a !== 1'b1; i++) tick(1);
        checks++; if (fd_a !== 1'b1) $display("FAIL ignore_frame_done: got %b want 1 within 400 cycles", fd_a); else passed++;
        tick(2);
        checks++; if (hs_a - h0 != 3) $display("FAIL ignore_start_count: got %0d want 3", hs_a - h0); else passed++;
        checks++; if (fdn_a - f0 != 1) $display("FAIL ignore_done_count: got %0d want 1", fdn_a - f0); else passed++;
        for (int i = 0; i < exp_a.size(); i++) begin
            checks++;
            if (rd_a >= obs_a.size()) begin $display("FAIL ignore_missing: block %0d absent, got %0d want %0d", i, obs_a.size(), rd_a + 1); continue; end
            passed++;
            o = obs_a[rd_a]; rd_a++;
            checks++; if (o !== exp_a[i]) $display("FAIL ignore_block%0d: got comp %0d dc %0d want comp %0d dc %0d", i, o.comp, $signed(o.dc), exp_a[i].comp, $signed(exp_a[i].dc)); else passed++;
        end
    endtask

    task automatic test_reset_mid;
        int h0, f0;
        bit seen;
        blk_t o;
        ifa.req_y = 1; ifa.req_cb = 1; ifa.req_cr = 1;
        pulse_a(16'd1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (ifa.huff_start === 1'b1) seen = 1'b1;
        end
        tick(3);
        checks++; if (!seen || busy_a !== 1'b1 || ifa.huff_active !== 1'b1) $display("FAIL midreset_setup: got start %b busy %b active %b want 111", seen, busy_a, ifa.huff_active); else passed++;
        #1 reset_n = 1'b0;
        #1;
        checks++; if ({busy_a, fd_a, te_a, ifa.huff_start, ifa.ack_y, ifa.ack_cb, ifa.ack_cr, ifa.comp_id, ifa.table_sel, ifa.dc_pred} !== 20'b0)
            $display("FAIL midreset_outputs: got %h want 0", {busy_a, fd_a, te_a, ifa.huff_start, ifa.ack_y, ifa.ack_cb, ifa.ack_cr, ifa.comp_id, ifa.table_sel, ifa.dc_pred}); else passed++;
        checks++; if (ifa.zigzag_pix_out !== '0) $display("FAIL midreset_zigzag: got %h want 0", ifa.zigzag_pix_out[63:0]); else passed++;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        exp_a.delete();
        exp_a.push_back(mkexp(2'd0, 10'd0, ifa.blk_y));
        exp_a.push_back(mkexp(2'd1, 10'd0, ifa.blk_cb));
        exp_a.push_back(mkexp(2'd2, 10'd0, ifa.blk_cr));
        h0 = hs_a; f0 = fdn_a; rd_a = obs_a.size();
        pulse_a(16'd1);
        for (int i = 0; i < 400 && fd_a !== 1'b1; i++) tick(1);
        checks++; if (fd_a !== 1'b1) $display("FAIL midreset_recover_done: got %b want 1 within 400 cycles", fd_a); else passed++;
        tick(2);
        checks++; if (hs_a - h0 != 3 || fdn_a - f0 != 1) $display("FAIL midreset_recover_counts: got %0d starts %0d done want 3 1", hs_a - h0, fdn_a - f0); else passed++;
        for (int i = 0; i < exp_a.size(); i++) begin
            checks++;
            if (rd_a >= obs_a.size()) begin $display("FAIL midreset_missing: block %0d absent, got %0d want %0d", i, obs_a.size(), rd_a + 1); continue; end
            passed++;
            o = obs_a[rd_a]; rd_a++;
            checks++; if (o !== exp_a[i]) $display("FAIL midreset_block%0d: got comp %0d dc %0d want comp %0d dc %0d", i, o.comp, $signed(o.dc), exp_a[i].comp, $signed(exp_a[i].dc)); else passed++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before 2000000 time units");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mcu_order();
        test_y4_order();
        test_timeout();
        test_zero_count();
        test_busy_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/huffman_mcu_scheduler.md
Name: huffman_mcu_scheduler

Overview:
- Shares the single Huffman entropy-encoder controller between three component block sources: Y, Cb and Cr.
- Sequences blocks in JPEG MCU order (Y×Y_BLOCKS, then Cb, then Cr) for a frame of mcu_count MCUs.
- Presents each 64×10-bit zigzag block stable to the encoder and issues a one-cycle start.
- Tracks encoder busy and maintains a per-component DC predictor.

Parameters:
- Y_BLOCKS, 1, luma blocks per MCU (1 = 4:4:4, 4 = 4:2:0); legal range 1..4.
- TIMEOUT_CYC, 1024, max cycles waited in WAIT_ACT or WAIT_DONE before abort.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  pulse; begins frame; honoured only in IDLE
- mcu_count  in  16  MCUs in frame; sampled on accepted frame_start
- req_y / req_cb / req_cr  in  1 each  source has a block ready (level)
- blk_y / blk_cb / blk_cr  in  640 each  zigzag blocks; coeff k = bits [10k+9:10k], signed
- ack_y / ack_cb / ack_cr  out  1 each  one-cycle pulse: block consumed
- huff_start  out  1  one-cycle start to encoder
- huff_active  in  1  encoder busy flag
- zigzag_pix_out  out  640  held block to encoder
- comp_id  out  2  0=Y, 1=Cb, 2=Cr
- table_sel  out  1  0=luma tables, 1=chroma tables
- dc_pred  out  10  signed previous DC of comp_id component
- busy  out  1  high when not IDLE
- frame_done  out  1  one-cycle pulse at normal frame end
- timeout_err  out  1  sticky; cleared by accepted frame_start

Behaviour:
- Reset: all outputs, counters, predictors and hold register are 0; state IDLE.
- All outputs are registered.
- States: IDLE, SELECT, START, WAIT_ACT, WAIT_DONE, DONE.
- IDLE:
  - On frame_start: latch mcu_count; clear mcu_cnt, seq_idx, all three dc predictors and timeout_err.
  - If mcu_count == 0, go to DONE; otherwise go to SELECT.
- seq_idx → component mapping:
  - 0..Y_BLOCKS-1 → Y.
  - Y_BLOCKS → Cb.
  - Y_BLOCKS+1 → Cr.
  - comp_id and table_sel track seq_idx; table_sel = (comp_id != 0).
- SELECT:
  - Wait for the req of the current component only; reqs of other components are ignored.
  - On req: latch that blk into zigzag_pix_out, pulse its ack next cycle, go to START.
- START: assert huff_start for exactly one cycle, clear timeout counter, go to WAIT_ACT.
  - Net effect: ack at cycle k+1 and huff_start at cycle k+2 after req is sampled at edge k.
- WAIT_ACT: go to WAIT_DONE when huff_active == 1.
- WAIT_DONE: when huff_active == 0:
  - Set dc_pred register of the current component to coeff 0 of zigzag_pix_out.
  - Advance seq_idx, wrapping to 0 after Y_BLOCKS+1.
  - On wrap, increment mcu_cnt; if mcu_cnt reaches mcu_count, go to DONE, else go to SELECT.
- zigzag_pix_out, comp_id and table_sel are held constant from SELECT exit until WAIT_DONE exit.
- dc_pred shows the predictor of comp_id. The update is visible only after the block completes.
- Timeout: in WAIT_ACT or WAIT_DONE, count cycles. On reaching TIMEOUT_CYC, set timeout_err and go to IDLE without frame_done.
- DONE: pulse frame_done for one cycle, go to IDLE.
- frame_start outside IDLE is ignored.
- Reset mid-frame returns immediately to the reset state; no ack or start is emitted.
- Simultaneous req of several components: only the scheduled component is served, so there is no priority logic.

Test Plan:
- Y_BLOCKS=1, mcu_count=2, all reqs held high, encoder model active for 20 cycles per block → 6 huff_start pulses, comp_id sequence 0,1,2,0,1,2, table_sel 0,1,1,0,1,1, a single frame_done.
- Y_BLOCKS=4, mcu_count=1 → ack_y×4 then ack_cb, ack_cr; req_cb asserted early is not acked until the 4th Y completes.
- DC predictor: Y blocks with coeff0 = 10'sd100 then 10'sd-3 → dc_pred reads 0 during block 1, 100 during block 2; after a new frame_start, reads 0.
- huff_active never rises, TIMEOUT_CYC=16 → timeout_err=1 on the 16th WAIT_ACT cycle, state IDLE, no frame_done; the next frame_start clears timeout_err.
- mcu_count=0 → frame_done 2 cycles after frame_start, no ack and no huff_start; frame_start while busy=1 → no effect.
- Assert reset_n low while in WAIT_DONE → all outputs 0 immediately; after release, a normal frame completes.
